nvm_arb_seq: RTL and testbench

- Arbitrates the single OTP/NVM macro port between three requesters: MCU code fetch, CSP (CC-based ISP over PD), and the I2C slave SFR path.
- Sequences read-access timing and program-pulse timing for the granted requester.
- Gates program cycles on VPP_EN (X0_NVMCTL bit 7).
- Sits between the NVMIO/OFS/DEC register logic and the NVM macro wrapper.

---
 rtl/nvm_arb_seq.sv | 245 ++++++++++++++++++++++++
 tb/tb_nvm_arb_seq.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nvm_arb_seq.sv
// nvm_arb_seq: arbitrates the single OTP/NVM macro port between MCU fetch,
// CSP and I2C requesters, and sequences read-enable and program-pulse timing
// for the granted requester. Program pulses are gated by vpp_en.
// Optional build macro NVM_ARB_RR_EN: round-robin between CSP and I2C
// (MCU keeps absolute priority). Without it: fixed MCU > CSP > I2C.
// Timing parameters assume RD_CYC >= 1, PG_CYC >= 2, REC_CYC >= 1.
module nvm_arb_seq #(
  parameter int AW      = 14,
  parameter int DW      = 8,
  parameter int RD_CYC  = 3,
  parameter int PG_CYC  = 40,
  parameter int REC_CYC = 2
) (
  input  logic          clk,
  input  logic          srstz,
  input  logic          mcu_req,
  input  logic [AW-1:0] mcu_adr,
  output logic          mcu_ack,
  input  logic          csp_req,
  input  logic          csp_we,
  input  logic [AW-1:0] csp_adr,
  input  logic [DW-1:0] csp_wdat,
  output logic          csp_ack,
  input  logic          i2c_req,
  input  logic          i2c_we,
  input  logic [AW-1:0] i2c_adr,
  input  logic [DW-1:0] i2c_wdat,
  output logic          i2c_ack,
  input  logic          vpp_en,
  input  logic          pg_err_clr,
  output logic [DW-1:0] rdat,
  output logic [AW-1:0] nvm_a,
  output logic          nvm_re,
  output logic          nvm_pg,
  output logic [DW-1:0] nvm_din,
  input  logic [DW-1:0] nvm_dout,
  output logic          busy,
  output logic          pg_err
);

  localparam logic [1:0] ID_MCU = 2'd0;
  localparam logic [1:0] ID_CSP = 2'd1;
  localparam logic [1:0] ID_I2C = 2'd2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    PG   = 3'd2,
    REC  = 3'd3,
    ACK  = 3'd4
  } state_t;

  state_t        state, state_nx;
  logic [7:0]    cnt, cnt_nx;
  logic          pg_on, pg_on_nx;
  logic [1:0]    id_q;
  logic [AW-1:0] adr_q;
  logic [DW-1:0] wdat_q;
  logic [DW-1:0] rdat_q;
  logic          pg_err_q;

  logic          gnt_vld;
  logic [1:0]    gnt_id;
  logic          gnt_we;
  logic [AW-1:0] gnt_adr;
  logic [DW-1:0] gnt_wdat;
  logic          ld;
  logic          rd_cap;
  logic          err_set;

`ifdef NVM_ARB_RR_EN
  logic rr_i2c;

  // RR pointer: after a CSP grant favour I2C on the next tie, and vice versa
  always_ff @(posedge clk) begin
    if (!srstz) begin
      rr_i2c <= 1'b0;
    end else if (ld && (gnt_id != ID_MCU)) begin
      rr_i2c <= (gnt_id == ID_CSP);
    end
  end
`endif

  // Pick the winner among pending requests and mux its transaction fields
  always_comb begin
    gnt_vld  = mcu_req | csp_req | i2c_req;
    gnt_id   = ID_MCU;
    if (mcu_req) begin
      gnt_id = ID_MCU;
    end
`ifdef NVM_ARB_RR_EN
    else if (csp_req && i2c_req) begin
      gnt_id = rr_i2c ? ID_I2C : ID_CSP;
    end
`endif
    else if (csp_req) begin
      gnt_id = ID_CSP;
    end else if (i2c_req) begin
      gnt_id = ID_I2C;
    end

    gnt_adr  = mcu_adr;
    gnt_we   = 1'b0;
    gnt_wdat = '0;
    case (gnt_id)
      ID_CSP: begin
        gnt_adr  = csp_adr;
        gnt_we   = csp_we;
        gnt_wdat = csp_wdat;
      end
      ID_I2C: begin
        gnt_adr  = i2c_adr;
        gnt_we   = i2c_we;
        gnt_wdat = i2c_wdat;
      end
      default: ;
    endcase
  end

  // State, cycle counter and pulse-phase registers
  always_ff @(posedge clk) begin
    if (!srstz) begin
      state <= IDLE;
      cnt   <= 8'd0;
      pg_on <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      pg_on <= pg_on_nx;
    end
  end

  // Next-state logic; PG has a setup phase (pg_on=0) then the pulse phase
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pg_on_nx = pg_on;
    ld       = 1'b0;
    rd_cap   = 1'b0;
    err_set  = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_vld) begin
          ld       = 1'b1;
          pg_on_nx = 1'b0;
          if (gnt_we) begin
            state_nx = PG;
          end else begin
            state_nx = RD;
            cnt_nx   = 8'(RD_CYC - 1);
          end
        end
      end
      RD: begin
        if (cnt == 8'd0) begin
          rd_cap   = 1'b1;
          state_nx = ACK;
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      PG: begin
        if (!pg_on) begin
          // Address/data already stable; decide whether to fire the pulse
          if (!vpp_en) begin
            err_set  = 1'b1;
            state_nx = ACK;
          end else begin
            pg_on_nx = 1'b1;
            cnt_nx   = 8'(PG_CYC - 1);
          end
        end else if (!vpp_en) begin
          err_set  = 1'b1;
          pg_on_nx = 1'b0;
          state_nx = REC;
          cnt_nx   = 8'(REC_CYC - 1);
        end else if (cnt == 8'd0) begin
          pg_on_nx = 1'b0;
          state_nx = REC;
          cnt_nx   = 8'(REC_CYC - 1);
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      REC: begin
        if (cnt == 8'd0) begin
          state_nx = ACK;
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      ACK: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Latch the granted transaction; requester inputs are ignored afterwards
  always_ff @(posedge clk) begin
    if (!srstz) begin
      adr_q  <= '0;
      wdat_q <= '0;
      id_q   <= ID_MCU;
    end else if (ld) begin
      adr_q  <= gnt_adr;
      wdat_q <= gnt_wdat;
      id_q   <= gnt_id;
    end
  end

  // Read data capture on the last RD cycle, held until the next read
  always_ff @(posedge clk) begin
    if (!srstz) begin
      rdat_q <= '0;
    end else if (rd_cap) begin
      rdat_q <= nvm_dout;
    end
  end

  // Sticky program error; a new error wins over a simultaneous clear
  always_ff @(posedge clk) begin
    if (!srstz) begin
      pg_err_q <= 1'b0;
    end else if (err_set) begin
      pg_err_q <= 1'b1;
    end else if (pg_err_clr) begin
      pg_err_q <= 1'b0;
    end
  end

  assign busy    = (state != IDLE);
  assign nvm_re  = (state == RD);
  assign nvm_pg  = (state == PG) && pg_on;
  assign nvm_a   = adr_q;
  assign nvm_din = wdat_q;
  assign rdat    = rdat_q;
  assign pg_err  = pg_err_q;
  assign mcu_ack = (state == ACK) && (id_q == ID_MCU);
  assign csp_ack = (state == ACK) && (id_q == ID_CSP);
  assign i2c_ack = (state == ACK) && (id_q == ID_I2C);

endmodule

// File: tb/tb_nvm_arb_seq.sv
// tb_nvm_arb_seq: self-checking bench for nvm_arb_seq with a behavioural
// macro/arbiter reference model and randomized multi-requester traffic.
module tb_nvm_arb_seq;

  localparam int AW      = 14;
  localparam int DW      = 8;
  localparam int RD_CYC  = 3;
  localparam int PG_CYC  = 40;
  localparam int REC_CYC = 2;

  logic          clk = 1'b0;
  logic          srstz;
  logic          mcu_req;
  logic [AW-1:0] mcu_adr;
  logic          mcu_ack;
  logic          csp_req;
  logic          csp_we;
  logic [AW-1:0] csp_adr;
  logic [DW-1:0] csp_wdat;
  logic          csp_ack;
  logic          i2c_req;
  logic          i2c_we;
  logic [AW-1:0] i2c_adr;
  logic [DW-1:0] i2c_wdat;
  logic          i2c_ack;
  logic          vpp_en;
  logic          pg_err_clr;
  logic [DW-1:0] rdat;
  logic [AW-1:0] nvm_a;
  logic          nvm_re;
  logic          nvm_pg;
  logic [DW-1:0] nvm_din;
  logic [DW-1:0] nvm_dout;
  logic          busy;
  logic          pg_err;

  always #5 clk = ~clk;

  nvm_arb_seq #(
    .AW(AW), .DW(DW), .RD_CYC(RD_CYC), .PG_CYC(PG_CYC), .REC_CYC(REC_CYC)
  ) dut (
    .clk(clk), .srstz(srstz),
    .mcu_req(mcu_req), .mcu_adr(mcu_adr), .mcu_ack(mcu_ack),
    .csp_req(csp_req), .csp_we(csp_we), .csp_adr(csp_adr),
    .csp_wdat(csp_wdat), .csp_ack(csp_ack),
    .i2c_req(i2c_req), .i2c_we(i2c_we), .i2c_adr(i2c_adr),
    .i2c_wdat(i2c_wdat), .i2c_ack(i2c_ack),
    .vpp_en(vpp_en), .pg_err_clr(pg_err_clr), .rdat(rdat),
    .nvm_a(nvm_a), .nvm_re(nvm_re), .nvm_pg(nvm_pg), .nvm_din(nvm_din),
    .nvm_dout(nvm_dout), .busy(busy), .pg_err(pg_err)
  );

  // Macro model: byte array, combinational read
  logic [DW-1:0] mem [0:(1<<AW)-1];
  assign nvm_dout = mem[nvm_a];

  int checks = 0;
  int errors = 0;

  // Pulse monitor: total program-pulse cycles and cycles with unstable a/din
  int            pg_total = 0;
  int            pg_bad   = 0;
  logic [AW-1:0] mon_a    = '0;
  logic [DW-1:0] mon_din  = '0;
  always @(negedge clk) begin
    if (nvm_pg === 1'b1) begin
      pg_total++;
      if (nvm_a !== mon_a || nvm_din !== mon_din) pg_bad++;
    end
  end

  // Arbiter reference: who wins given pending set {i2c,csp,mcu}
  logic rr_m = 1'b0;
  function automatic int pick(input logic [2:0] p);
    if (p[0]) return 0;
`ifdef NVM_ARB_RR_EN
    if (p[1] && p[2]) return rr_m ? 2 : 1;
`endif
    if (p[1]) return 1;
    if (p[2]) return 2;
    return -1;
  endfunction

  task automatic note_grant(input int k);
    if (k == 1) rr_m = 1'b1;
    else if (k == 2) rr_m = 1'b0;
  endtask

  // Wait (bounded) for any ack; lat counts cycles from the call, busy per cycle
  task automatic wait_ack(output logic [2:0] who, output int lat,
                          output logic [31:0] bmask, output logic [DW-1:0] rd,
                          output logic perr);
    who = 3'b000; lat = 0; bmask = '0; rd = '0; perr = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      lat++;
      if (lat <= 32) bmask[lat-1] = busy;
      if (mcu_ack || csp_ack || i2c_ack) begin
        who  = {i2c_ack, csp_ack, mcu_ack};
        rd   = rdat;
        perr = pg_err;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    srstz = 1'b0; mcu_req = 1'b0; csp_req = 1'b0; i2c_req = 1'b0;
    pg_err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 srstz = 1'b1;
    rr_m = 1'b0;
  endtask

  task automatic test_reset();
    srstz = 1'b0; mcu_req = 1'b1; csp_req = 1'b1; i2c_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if ({mcu_ack, csp_ack, i2c_ack} !== 3'b000) begin errors++; $display("FAIL rst_ack got %b want 000", {mcu_ack, csp_ack, i2c_ack}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if ({nvm_re, nvm_pg} !== 2'b00) begin errors++; $display("FAIL rst_re_pg got %b want 00", {nvm_re, nvm_pg}); end
    checks++; if (rdat !== '0) begin errors++; $display("FAIL rst_rdat got %h want 00", rdat); end
    checks++; if (pg_err !== 1'b0) begin errors++; $display("FAIL rst_pg_err got %b want 0", pg_err); end
    checks++; if (nvm_a !== '0 || nvm_din !== '0) begin errors++; $display("FAIL rst_a_din got %h/%h want 0/0", nvm_a, nvm_din); end
    @(posedge clk); #1;
    mcu_req = 1'b0; csp_req = 1'b0;
    srstz = 1'b1; rr_m = 1'b0;
  endtask

  task automatic test_read();
    logic [2:0] who; int lat; logic [31:0] bm; logic [DW-1:0] rd; logic pe;
    mem[14'h440] = 8'h55;
    csp_we = 1'b0; csp_adr = 14'h440; csp_req = 1'b1;
    note_grant(1);
    wait_ack(who, lat, bm, rd, pe);
    csp_req = 1'b0;
    checks++; if (who !== 3'b010) begin errors++; $display("FAIL rd_who got %b want 010", who); end
    checks++; if (lat != RD_CYC + 2) begin errors++; $display("FAIL rd_latency got %0d want %0d", lat, RD_CYC + 2); end
    checks++; if (bm[4:0] !== 5'b11110) begin errors++; $display("FAIL rd_busy got %b want 11110", bm[4:0]); end
    checks++; if (rd !== 8'h55) begin errors++; $display("FAIL rd_data got %h want 55", rd); end
    @(negedge clk);
    checks++; if (rdat !== 8'h55 || busy !== 1'b0) begin errors++; $display("FAIL rd_hold got %h/%b want 55/0", rdat, busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_program();
    logic [2:0] who; int lat; logic [31:0] bm; logic [DW-1:0] rd; logic pe;
    int p0, b0;
    vpp_en = 1'b1;
    csp_we = 1'b1; csp_adr = 14'h302; csp_wdat = 8'h12;
    mon_a = 14'h302; mon_din = 8'h12; p0 = pg_total; b0 = pg_bad;
    csp_req = 1'b1;
    note_grant(1);
    wait_ack(who, lat, bm, rd, pe);
    csp_req = 1'b0;
    mem[14'h302] = 8'h12;
    checks++; if (who !== 3'b010) begin errors++; $display("FAIL pg_who got %b want 010", who); end
    checks++; if (pg_total - p0 != PG_CYC) begin errors++; $display("FAIL pg_width got %0d want %0d", pg_total - p0, PG_CYC); end
    checks++; if (pg_bad - b0 != 0) begin errors++; $display("FAIL pg_stable got %0d want 0", pg_bad - b0); end
    checks++; if (lat != PG_CYC + REC_CYC + 3) begin errors++; $display("FAIL pg_latency got %0d want %0d", lat, PG_CYC + REC_CYC + 3); end
    checks++; if (pe !== 1'b0 || pg_err !== 1'b0) begin errors++; $display("FAIL pg_err got %b want 0", pe); end
  endtask

  task automatic test_program_novpp();
    logic [2:0] who; int lat; logic [31:0] bm; logic [DW-1:0] rd; logic pe;
    int p0;
    vpp_en = 1'b0;
    csp_we = 1'b1; csp_adr = 14'h302; csp_wdat = 8'h12;
    p0 = pg_total;
    csp_req = 1'b1;
    note_grant(1);
    wait_ack(who, lat, bm, rd, pe);
    csp_req = 1'b0;
    checks++; if (who !== 3'b010) begin errors++; $display("FAIL novpp_who got %b want 010", who); end
    checks++; if (lat != 3) begin errors++; $display("FAIL novpp_latency got %0d want 3", lat); end
    checks++; if (pg_total - p0 != 0) begin errors++; $display("FAIL novpp_pulse got %0d want 0", pg_total - p0); end
    checks++; if (pe !== 1'b1) begin errors++; $display("FAIL novpp_err got %b want 1", pe); end
    pg_err_clr = 1'b1;
    @(posedge clk); #1;
    pg_err_clr = 1'b0;
    checks++; if (pg_err !== 1'b0) begin errors++; $display("FAIL err_clr got %b want 0", pg_err); end
    // clear held through a failing attempt: the new error still sets
    pg_err_clr = 1'b1;
    csp_req = 1'b1;
    note_grant(1);
    wait_ack(who, lat, bm, rd, pe);
    csp_req = 1'b0;
    checks++; if (pe !== 1'b1) begin errors++; $display("FAIL err_set_wins got %b want 1", pe); end
    checks++; if (pg_err !== 1'b0) begin errors++; $display("FAIL err_clr_after got %b want 0", pg_err); end
    pg_err_clr = 1'b0;
    vpp_en = 1'b1;
  endtask

  task automatic test_arbitration();
    logic [2:0] who; int lat; logic [31:0] bm; logic [DW-1:0] rd; logic pe;
    logic [2:0] pend; logic [AW-1:0] a [3]; int k;
    do_reset();
    a[0] = 14'h0010; a[1] = 14'h0a21; a[2] = 14'h1f32;
    mcu_adr = a[0]; csp_adr = a[1]; i2c_adr = a[2];
    csp_we = 1'b0; i2c_we = 1'b0;
    mcu_req = 1'b1; csp_req = 1'b1; i2c_req = 1'b1;
    pend = 3'b111;
    for (int n = 0; n < 3; n++) begin
      k = pick(pend); note_grant(k);
      wait_ack(who, lat, bm, rd, pe);
      checks++; if (who !== (3'b001 << k)) begin errors++; $display("FAIL arb_order%0d got %b want %b", n, who, 3'b001 << k); end
      checks++; if (rd !== mem[a[k]]) begin errors++; $display("FAIL arb_rdat%0d got %h want %h", n, rd, mem[a[k]]); end
      pend[k] = 1'b0;
      mcu_req = pend[0]; csp_req = pend[1]; i2c_req = pend[2];
    end
    // CSP never lets go; I2C waits behind it
    csp_req = 1'b1; i2c_req = 1'b1;
    for (int n = 0; n < 2; n++) begin
      k = pick(3'b110); note_grant(k);
      wait_ack(who, lat, bm, rd, pe);
      checks++; if (who !== (3'b001 << k)) begin errors++; $display("FAIL arb_hold%0d got %b want %b", n, who, 3'b001 << k); end
      if (k == 2) i2c_req = 1'b0;
    end
    csp_req = 1'b0; i2c_req = 1'b0;
    if (pick(3'b110) == 2) begin
      // I2C still pending in model only if it was never served; drain it
      i2c_req = 1'b1; note_grant(2);
      wait_ack(who, lat, bm, rd, pe);
      i2c_req = 1'b0;
    end
  endtask

  task automatic test_vpp_drop();
    logic [2:0] who; int lat; logic [31:0] bm; logic [DW-1:0] rd; logic pe;
    int p0;
    vpp_en = 1'b1;
    csp_we = 1'b1; csp_adr = 14'h0123; csp_wdat = 8'ha5;
    mon_a = 14'h0123; mon_din = 8'ha5; p0 = pg_total;
    csp_req = 1'b1;
    note_grant(1);
    fork
      wait_ack(who, lat, bm, rd, pe);
      begin
        repeat (11) @(posedge clk);
        #1 vpp_en = 1'b0;
      end
    join
    csp_req = 1'b0;
    checks++; if (pg_total - p0 != 10) begin errors++; $display("FAIL drop_width got %0d want 10", pg_total - p0); end
    checks++; if (who !== 3'b010) begin errors++; $display("FAIL drop_who got %b want 010", who); end
    checks++; if (lat != 10 + REC_CYC + 3) begin errors++; $display("FAIL drop_latency got %0d want %0d", lat, 10 + REC_CYC + 3); end
    checks++; if (pe !== 1'b1) begin errors++; $display("FAIL drop_err got %b want 1", pe); end
    vpp_en = 1'b1;
    pg_err_clr = 1'b1;
    @(posedge clk); #1;
    pg_err_clr = 1'b0;
  endtask

  task automatic test_reset_mid_pg();
    logic [2:0] who; int lat; logic [31:0] bm; logic [DW-1:0] rd; logic pe;
    int p0, acks;
    vpp_en = 1'b1;
    csp_we = 1'b1; csp_adr = 14'h02aa; csp_wdat = 8'h3c;
    mon_a = 14'h02aa; mon_din = 8'h3c; p0 = pg_total;
    csp_req = 1'b1;
    repeat (21) @(posedge clk);
    #1 srstz = 1'b0; csp_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (nvm_pg !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_pg_busy got %b/%b want 0/0", nvm_pg, busy); end
    checks++; if (pg_total - p0 != 20) begin errors++; $display("FAIL midrst_width got %0d want 20", pg_total - p0); end
    checks++; if (rdat !== '0) begin errors++; $display("FAIL midrst_rdat got %h want 00", rdat); end
    @(posedge clk); #1 srstz = 1'b1; rr_m = 1'b0;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (mcu_ack || csp_ack || i2c_ack) acks++;
    end
    checks++; if (acks != 0) begin errors++; $display("FAIL midrst_noack got %0d want 0", acks); end
    @(posedge clk); #1;
    i2c_we = 1'b0; i2c_adr = 14'h07ff; i2c_req = 1'b1;
    note_grant(2);
    wait_ack(who, lat, bm, rd, pe);
    i2c_req = 1'b0;
    checks++; if (who !== 3'b100) begin errors++; $display("FAIL midrst_next_who got %b want 100", who); end
    checks++; if (lat != RD_CYC + 2) begin errors++; $display("FAIL midrst_next_lat got %0d want %0d", lat, RD_CYC + 2); end
    checks++; if (rd !== mem[14'h07ff]) begin errors++; $display("FAIL midrst_next_rdat got %h want %h", rd, mem[14'h07ff]); end
  endtask

  task automatic test_random();
    logic [2:0] who; int lat; logic [31:0] bm; logic [DW-1:0] rd; logic pe;
    logic [2:0] pend; logic [AW-1:0] a [3]; logic [DW-1:0] d [3]; logic w [3];
    logic vpp, m_err; int k, p0, b0, exp_lat;
    do_reset();
    m_err = 1'b0;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        pg_err_clr = 1'b1;
        @(posedge clk); #1;
        pg_err_clr = 1'b0;
        m_err = 1'b0;
      end
      pend = 3'($urandom_range(1, 7));
      for (int j = 0; j < 3; j++) begin
        a[j] = AW'($urandom);
        d[j] = DW'($urandom);
        w[j] = (j != 0) && ($urandom_range(0, 1) == 1);
      end
      vpp = ($urandom_range(0, 4) != 0);
      vpp_en = vpp;
      mcu_adr = a[0];
      csp_adr = a[1]; csp_we = w[1]; csp_wdat = d[1];
      i2c_adr = a[2]; i2c_we = w[2]; i2c_wdat = d[2];
      mcu_req = pend[0]; csp_req = pend[1]; i2c_req = pend[2];
      while (pend != 3'b000) begin
        k = pick(pend); note_grant(k);
        mon_a = a[k]; mon_din = d[k]; p0 = pg_total; b0 = pg_bad;
        wait_ack(who, lat, bm, rd, pe);
        if (!w[k]) exp_lat = RD_CYC + 2;
        else if (vpp) exp_lat = PG_CYC + REC_CYC + 3;
        else exp_lat = 3;
        if (w[k] && !vpp) m_err = 1'b1;
        checks++; if (who !== (3'b001 << k)) begin errors++; $display("FAIL rnd_who it%0d got %b want %b", it, who, 3'b001 << k); end
        checks++; if (lat != exp_lat) begin errors++; $display("FAIL rnd_lat it%0d got %0d want %0d", it, lat, exp_lat); end
        checks++; if (pe !== m_err) begin errors++; $display("FAIL rnd_err it%0d got %b want %b", it, pe, m_err); end
        if (!w[k]) begin
          checks++; if (rd !== mem[a[k]]) begin errors++; $display("FAIL rnd_rdat it%0d got %h want %h", it, rd, mem[a[k]]); end
        end else begin
          checks++; if (pg_total - p0 != (vpp ? PG_CYC : 0) || pg_bad != b0) begin errors++; $display("FAIL rnd_pulse it%0d got %0d/%0d want %0d/0", it, pg_total - p0, pg_bad - b0, vpp ? PG_CYC : 0); end
          if (vpp) mem[a[k]] = d[k];
        end
        pend[k] = 1'b0;
        mcu_req = pend[0]; csp_req = pend[1]; i2c_req = pend[2];
      end
    end
    vpp_en = 1'b1;
  endtask

  initial begin
    srstz = 1'b0; mcu_req = 1'b0; mcu_adr = '0;
    csp_req = 1'b0; csp_we = 1'b0; csp_adr = '0; csp_wdat = '0;
    i2c_req = 1'b0; i2c_we = 1'b0; i2c_adr = '0; i2c_wdat = '0;
    vpp_en = 1'b1; pg_err_clr = 1'b0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    test_reset();
    test_read();
    test_program();
    test_program_novpp();
    test_arbitration();
    test_vpp_drop();
    test_reset_mid_pg();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
